alu_ac_unit: RTL and testbench



---
 rtl/alu_ac_unit.sv | 136 +++++++++++++
 tb/tb_alu_ac_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ac_unit.sv
// Accumulator ALU stage: combines the B-bus operand with AC, maintains the zero flag,
// and runs a 16-iteration shift-add multiply with a start/busy/done handshake.
module alu_ac_unit #(
    parameter int WIDTH      = 16,
    parameter int MUL_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] B_bus,
    input  logic [3:0]       alu_op,
    input  logic             start,
    output logic [WIDTH-1:0] AC,
    output logic             Z,
    output logic             busy,
    output logic             done
);

    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    localparam logic [3:0] OP_LDB  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_INC  = 4'b0100;
    localparam logic [3:0] OP_DEC  = 4'b0101;
    localparam logic [3:0] OP_CLR  = 4'b0110;
    localparam logic [3:0] OP_SHL  = 4'b0111;
    localparam logic [3:0] OP_SHR  = 4'b1000;
    localparam logic [3:0] OP_SHRN = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;

    typedef enum logic {IDLE, MUL_RUN} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] ac_next;
    logic             z_next;
    logic             done_next;
    logic [WIDTH-1:0] mcand, mcand_next;
    logic [WIDTH-1:0] mplier, mplier_next;
    logic [WIDTH-1:0] prod, prod_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [WIDTH-1:0] prod_sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_wr;

    assign busy = (state == MUL_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            AC     <= '0;
            Z      <= 1'b1;
            done   <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            cnt    <= '0;
        end else begin
            AC     <= ac_next;
            Z      <= z_next;
            done   <= done_next;
            mcand  <= mcand_next;
            mplier <= mplier_next;
            prod   <= prod_next;
            cnt    <= cnt_next;
        end
    end

    // Only the low WIDTH product bits are kept, so partial sums wrap at WIDTH.
    always_comb begin
        state_next  = state;
        ac_next     = AC;
        z_next      = Z;
        done_next   = 1'b0;
        mcand_next  = mcand;
        mplier_next = mplier;
        prod_next   = prod;
        cnt_next    = cnt;
        alu_res     = AC;
        alu_wr      = 1'b0;
        prod_sum    = prod + (mplier[0] ? mcand : '0);

        case (state)
            IDLE: begin
                if (start) begin
                    if (alu_op == OP_MUL) begin
                        mcand_next  = B_bus;
                        mplier_next = AC;
                        prod_next   = '0;
                        cnt_next    = '0;
                        state_next  = MUL_RUN;
                    end else begin
                        done_next = 1'b1;
                        // Ops that ignore the B-bus never reference it, so an X there stays out.
                        case (alu_op)
                            OP_LDB:  begin alu_res = B_bus;            alu_wr = 1'b1; end
                            OP_ADD:  begin alu_res = AC + B_bus;       alu_wr = 1'b1; end
                            OP_SUB:  begin alu_res = AC - B_bus;       alu_wr = 1'b1; end
                            OP_INC:  begin alu_res = AC + WIDTH'(1);   alu_wr = 1'b1; end
                            OP_DEC:  begin alu_res = AC - WIDTH'(1);   alu_wr = 1'b1; end
                            OP_CLR:  begin alu_res = '0;               alu_wr = 1'b1; end
                            OP_SHL:  begin alu_res = AC << 1;          alu_wr = 1'b1; end
                            OP_SHR:  begin alu_res = AC >> 1;          alu_wr = 1'b1; end
                            OP_SHRN: begin alu_res = AC >> B_bus[3:0]; alu_wr = 1'b1; end
                            default: begin alu_res = AC;               alu_wr = 1'b0; end
                        endcase
                        if (alu_wr) begin
                            ac_next = alu_res;
                            z_next  = (alu_res == '0);
                        end
                    end
                end
            end
            MUL_RUN: begin
                prod_next   = prod_sum;
                mcand_next  = mcand << 1;
                mplier_next = mplier >> 1;
                cnt_next    = cnt + CW'(1);
                if (cnt == CW'(MUL_CYCLES - 1)) begin
                    ac_next    = prod_sum;
                    z_next     = (prod_sum == '0);
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_ac_unit.sv
// Bench for alu_ac_unit: directed vector table, multi-cycle corner sequences,
// and random ops checked against an arithmetic reference model.
module tb_alu_ac_unit;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_LDB  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_INC  = 4'b0100;
    localparam logic [3:0] OP_DEC  = 4'b0101;
    localparam logic [3:0] OP_CLR  = 4'b0110;
    localparam logic [3:0] OP_SHL  = 4'b0111;
    localparam logic [3:0] OP_SHR  = 4'b1000;
    localparam logic [3:0] OP_SHRN = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] b;
        logic [15:0] ac;
        logic        z;
        int          lat;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] B_bus;
    logic [3:0]  alu_op;
    logic        start;
    logic [15:0] AC;
    logic        Z;
    logic        busy;
    logic        done;

    int checkCount = 0;
    int passCount  = 0;

    alu_ac_unit #(.WIDTH(16), .MUL_CYCLES(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .B_bus  (B_bus),
        .alu_op (alu_op),
        .start  (start),
        .AC     (AC),
        .Z      (Z),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulses start for one edge, waits (bounded) for done, then one more edge to see done drop.
    task automatic applyStimulus(input logic [3:0] op, input logic [15:0] b,
                                 output int lat, output logic doneDropped);
        @(negedge clk);
        alu_op = op;
        B_bus  = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        B_bus = 16'($urandom);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        @(posedge clk);
        #1;
        doneDropped = (done === 1'b0);
    endtask

    function automatic void modelOp(input logic [3:0] op, input logic [15:0] b,
                                    inout logic [15:0] ac, inout logic z);
        int unsigned      a  = ac;
        int unsigned      bv = b;
        int unsigned      r  = a;
        longint unsigned  p;
        bit               wr = 1'b1;
        case (op)
            OP_LDB:  r = bv;
            OP_ADD:  r = (a + bv) % 65536;
            OP_SUB:  r = (a + 65536 - bv) % 65536;
            OP_INC:  r = (a + 1) % 65536;
            OP_DEC:  r = (a + 65535) % 65536;
            OP_CLR:  r = 0;
            OP_SHL:  r = (a * 2) % 65536;
            OP_SHR:  r = a / 2;
            OP_SHRN: r = a / (32'd1 << (bv % 16));
            OP_MUL: begin
                p = longint'(a) * longint'(bv);
                r = 32'(p % 64'd65536);
            end
            default: wr = 1'b0;
        endcase
        if (wr) begin
            ac = r[15:0];
            z  = (r == 0);
        end
    endfunction

    initial begin
        vec_t        vecs[21];
        int          lat;
        logic        dropped;
        logic        sawDone;
        logic [15:0] mAc;
        logic        mZ;
        logic [3:0]  rop;
        logic [15:0] rb;

        rst_n  = 1'b0;
        start  = 1'b0;
        alu_op = OP_NOP;
        B_bus  = 16'h0000;
        #12;
        checkOutput("reset AC", AC, 16'h0000);
        checkOutput("reset Z", Z, 1'b1);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        vecs[0]  = '{OP_LDB,  16'h0005, 16'h0005, 1'b0, 0,  "ldb 5"};
        vecs[1]  = '{OP_ADD,  16'h0003, 16'h0008, 1'b0, 0,  "add 3"};
        vecs[2]  = '{OP_SUB,  16'h0008, 16'h0000, 1'b1, 0,  "sub equal"};
        vecs[3]  = '{OP_DEC,  16'hxxxx, 16'hFFFF, 1'b0, 0,  "dec wrap"};
        vecs[4]  = '{OP_INC,  16'hxxxx, 16'h0000, 1'b1, 0,  "inc wrap"};
        vecs[5]  = '{OP_LDB,  16'h8001, 16'h8001, 1'b0, 0,  "ldb 8001"};
        vecs[6]  = '{OP_SHL,  16'hxxxx, 16'h0002, 1'b0, 0,  "shl"};
        vecs[7]  = '{OP_SHR,  16'hxxxx, 16'h0001, 1'b0, 0,  "shr"};
        vecs[8]  = '{OP_LDB,  16'hF000, 16'hF000, 1'b0, 0,  "ldb f000"};
        vecs[9]  = '{OP_SHRN, 16'h0004, 16'h0F00, 1'b0, 0,  "shrn 4"};
        vecs[10] = '{OP_INC,  16'hxxxx, 16'h0F01, 1'b0, 0,  "inc b=x"};
        vecs[11] = '{OP_NOP,  16'hxxxx, 16'h0F01, 1'b0, 0,  "nop"};
        vecs[12] = '{4'b1111, 16'h0000, 16'h0F01, 1'b0, 0,  "op 1111"};
        vecs[13] = '{OP_CLR,  16'hxxxx, 16'h0000, 1'b1, 0,  "clr"};
        vecs[14] = '{4'b1011, 16'h1234, 16'h0000, 1'b1, 0,  "op 1011 keeps z"};
        vecs[15] = '{OP_LDB,  16'h0012, 16'h0012, 1'b0, 0,  "ldb 12"};
        vecs[16] = '{OP_MUL,  16'h0034, 16'h03A8, 1'b0, 16, "mul 12x34"};
        vecs[17] = '{OP_LDB,  16'h0100, 16'h0100, 1'b0, 0,  "ldb 100"};
        vecs[18] = '{OP_MUL,  16'h0100, 16'h0000, 1'b1, 16, "mul overflow"};
        vecs[19] = '{OP_LDB,  16'hFFFF, 16'hFFFF, 1'b0, 0,  "ldb ffff"};
        vecs[20] = '{OP_MUL,  16'h0002, 16'hFFFE, 1'b0, 16, "mul ffff x2"};

        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i].op, vecs[i].b, lat, dropped);
            checkOutput({vecs[i].name, " AC"}, AC, vecs[i].ac);
            checkOutput({vecs[i].name, " Z"}, Z, vecs[i].z);
            checkOutput({vecs[i].name, " latency"}, lat, vecs[i].lat);
            checkOutput({vecs[i].name, " done width"}, dropped, 1'b1);
        end

        // MUL with a stray ADD start at edge k+5 and a wandering B-bus.
        applyStimulus(OP_LDB, 16'h0012, lat, dropped);
        @(negedge clk);
        alu_op = OP_MUL;
        B_bus  = 16'h0034;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("mul busy at k", {busy, done}, 2'b10);
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            if (j == 5) begin
                start  = 1'b1;
                alu_op = OP_ADD;
                B_bus  = 16'h0001;
            end else begin
                start  = 1'b0;
                alu_op = 4'($urandom);
                B_bus  = 16'($urandom);
            end
            @(posedge clk);
            #1;
            if (j < 16) begin
                checkOutput($sformatf("mul busy k+%0d", j), {busy, done}, 2'b10);
            end else begin
                checkOutput("mul end busy/done", {busy, done}, 2'b01);
                checkOutput("mul end AC", AC, 16'h03A8);
                checkOutput("mul end Z", Z, 1'b0);
            end
        end
        @(posedge clk);
        #1;
        checkOutput("mul done single pulse", done, 1'b0);
        checkOutput("mul AC after ignored add", AC, 16'h03A8);

        // A start held through the done cycle is accepted immediately.
        @(negedge clk);
        alu_op = OP_LDB;
        B_bus  = 16'h0007;
        start  = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("b2b first AC", AC, 16'h0007);
        @(negedge clk);
        alu_op = OP_INC;
        @(posedge clk);
        #1;
        checkOutput("b2b second AC", AC, 16'h0008);
        checkOutput("b2b second done", done, 1'b1);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("b2b done drops", done, 1'b0);

        // Asynchronous reset in the middle of a multiply.
        applyStimulus(OP_LDB, 16'h0003, lat, dropped);
        @(negedge clk);
        alu_op = OP_MUL;
        B_bus  = 16'h0005;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midmul reset AC", AC, 16'h0000);
        checkOutput("midmul reset Z", Z, 1'b1);
        checkOutput("midmul reset busy/done", {busy, done}, 2'b00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sawDone = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) sawDone = 1'b1;
        end
        checkOutput("midmul no done", sawDone, 1'b0);
        checkOutput("midmul AC stays 0", AC, 16'h0000);
        applyStimulus(OP_LDB, 16'h1234, lat, dropped);
        checkOutput("post reset ldb AC", AC, 16'h1234);
        checkOutput("post reset ldb Z", Z, 1'b0);
        checkOutput("post reset ldb latency", lat, 0);

        // Random ops against the arithmetic model.
        mAc = 16'h1234;
        mZ  = 1'b0;
        for (int i = 0; i < 150; i++) begin
            rop = 4'($urandom_range(0, 15));
            rb  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            applyStimulus(rop, rb, lat, dropped);
            modelOp(rop, rb, mAc, mZ);
            checkOutput($sformatf("rand %0d op %0d AC", i, rop), AC, mAc);
            checkOutput($sformatf("rand %0d op %0d Z", i, rop), Z, mZ);
            checkOutput($sformatf("rand %0d op %0d latency", i, rop), lat, (rop == OP_MUL) ? 16 : 0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
